// File: rtl/fir_accumulator.sv
// FIR output accumulator: sums TAPS consecutive multiplier products into one sample
// and presents it on a registered valid/ready output with single-slot buffering.
module fir_accumulator #(
    parameter int unsigned N    = 16,
    parameter int unsigned TAPS = 8,
    parameter int unsigned CW   = 3,
    parameter int unsigned AW   = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [N-1:0]  prod_in,
    input  logic          prod_valid,
    output logic          prod_ready,
    output logic [CW-1:0] tap_idx,
    output logic [AW-1:0] acc_out,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic          busy
);

    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    logic [CW-1:0] tap_r, tap_nxt_s;
    logic [AW-1:0] acc_r, acc_nxt_s;
    logic [AW-1:0] acc_out_r, acc_out_nxt_s;
    logic          acc_valid_r, acc_valid_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic [AW-1:0] prod_ext_s, sum_s;
    logic          last_s, accept_s, consume_s;

    // The final product of a frame may only enter when the output slot is free or draining.
    assign last_s     = (tap_r == LAST_TAP);
    assign prod_ready = !(last_s && acc_valid_r && !acc_ready);
    assign accept_s   = prod_valid && prod_ready;
    assign consume_s  = acc_valid_r && acc_ready;
    assign prod_ext_s = {{(AW-N){1'b0}}, prod_in};
    assign sum_s      = acc_r + prod_ext_s;

    // Next-state: clr wins over accept and consume; frame end loads the output slot.
    always_comb begin
        tap_nxt_s       = tap_r;
        acc_nxt_s       = acc_r;
        acc_out_nxt_s   = acc_out_r;
        acc_valid_nxt_s = acc_valid_r;
        if (clr) begin
            tap_nxt_s       = {CW{1'b0}};
            acc_nxt_s       = {AW{1'b0}};
            acc_out_nxt_s   = {AW{1'b0}};
            acc_valid_nxt_s = 1'b0;
        end else begin
            if (accept_s) begin
                if (tap_r == {CW{1'b0}}) begin
                    acc_nxt_s = prod_ext_s;
                end else begin
                    acc_nxt_s = sum_s;
                end
                if (last_s) begin
                    tap_nxt_s = {CW{1'b0}};
                end else begin
                    tap_nxt_s = tap_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                tap_nxt_s = tap_r;
            end
            if (accept_s && last_s) begin
                acc_out_nxt_s   = sum_s;
                acc_valid_nxt_s = 1'b1;
            end else if (consume_s) begin
                acc_valid_nxt_s = 1'b0;
            end else begin
                acc_valid_nxt_s = acc_valid_r;
            end
        end
        busy_nxt_s = (tap_nxt_s != {CW{1'b0}});
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_r       <= {CW{1'b0}};
            acc_r       <= {AW{1'b0}};
            acc_out_r   <= {AW{1'b0}};
            acc_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            tap_r       <= tap_nxt_s;
            acc_r       <= acc_nxt_s;
            acc_out_r   <= acc_out_nxt_s;
            acc_valid_r <= acc_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign tap_idx   = tap_r;
    assign acc_out   = acc_out_r;
    assign acc_valid = acc_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fir_accumulator.sv
// Randomized and directed bench for fir_accumulator against a queue-based frame model.
module tb_fir_accumulator;

    localparam int N = 16, TAPS = 8, CW = 3, AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [N-1:0]  prod_in = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [CW-1:0] tap_idx;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ready = 1'b1;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    fir_accumulator #(.N(N), .TAPS(TAPS), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .tap_idx(tap_idx), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: products of the open frame, and a one-deep result slot.
    int unsigned frame_q[$];
    int unsigned m_out   = 0;
    bit          m_valid = 1'b0;

    function automatic bit m_ready();
        return !((frame_q.size() == TAPS - 1) && m_valid && !acc_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            m_out   = 0;
            m_valid = 1'b0;
        end else if (clr) begin
            frame_q.delete();
            m_out   = 0;
            m_valid = 1'b0;
        end else begin
            bit consume, accept;
            int unsigned s;
            consume = m_valid && acc_ready;
            accept  = prod_valid && m_ready();
            if (accept) frame_q.push_back(int'(prod_in));
            if (frame_q.size() == TAPS) begin
                s = 0;
                foreach (frame_q[i]) s += frame_q[i];
                m_out   = s;
                m_valid = 1'b1;
                frame_q.delete();
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("prod_ready", prod_ready, m_ready());
        check("tap_idx", tap_idx, frame_q.size());
        check("busy", busy, frame_q.size() != 0);
        check("acc_valid", acc_valid, m_valid);
        check("acc_out", acc_out, m_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v);
        bit ok;
        prod_in    = N'(v);
        prod_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = m_ready();
            tick();
        end
        if (!ok) check("send_timeout", 0, 1);
        prod_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        check("rst_acc_valid", acc_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_tap_idx", tap_idx, 0);
        check("rst_busy", busy, 0);
        #1 rst = 1'b0;
        #1 check("rst_prod_ready", prod_ready, 1);
    endtask

    initial begin
        int unsigned gap_vals[8];
        gap_vals = '{5, 0, 7, 1, 2, 3, 4, 6};
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        tick();

        // Basic frame
        acc_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(i);
        check("basic_valid", acc_valid, 1);
        check("basic_sum", acc_out, 36);
        tick();
        check("basic_one_cycle", acc_valid, 0);

        // Max values
        for (int i = 0; i < 8; i++) send(32'hFE01);
        check("max_sum", acc_out, 520200);
        tick();

        // Backpressure
        acc_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(i);
        for (int i = 1; i <= 7; i++) send(10 * i);
        prod_in = N'(80);
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("bp_stall", prod_ready, 0);
        check("bp_hold", acc_out, 36);
        check("bp_tap", tap_idx, 7);
        acc_ready = 1'b1;
        tick();
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        check("bp_new_valid", acc_valid, 1);
        check("bp_new_sum", acc_out, 360);
        acc_ready = 1'b1;
        tick();

        // Gaps
        for (int i = 0; i < 8; i++) begin
            send(gap_vals[i]);
            tick();
            tick();
        end
        check("gap_sum", acc_out, 28);

        // Abort by clr
        for (int i = 0; i < 3; i++) send(100);
        prod_in = N'(100);
        prod_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        prod_valid = 1'b0;
        check("clr_tap", tap_idx, 0);
        check("clr_busy", busy, 0);
        check("clr_valid", acc_valid, 0);
        for (int i = 0; i < 8; i++) send(2);
        check("clr_next_sum", acc_out, 16);
        tick();

        // Abort by rst
        for (int i = 0; i < 5; i++) send(100);
        pulse_rst();
        tick();
        for (int i = 0; i < 8; i++) send(2);
        check("rst_next_sum", acc_out, 16);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            prod_valid = ($urandom_range(0, 3) != 0);
            prod_in    = N'($urandom_range(0, 65535));
            acc_ready  = ($urandom_range(0, 2) != 0);
            clr        = ($urandom_range(0, 199) == 0);
            tick();
        end
        prod_valid = 1'b0;
        clr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
